// File: rtl/boot_load_arbiter_pkg.sv
// Shared loader types: state encoding and image framing constants.
package boot_load_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_HDR  = 2'd0,
        ST_DATA = 2'd1,
        ST_RUN  = 2'd2,
        ST_ERR  = 2'd3
    } load_state_e;

    localparam int HDR_BYTES  = 4;
    localparam int WORD_BYTES = 4;

endpackage

// File: rtl/boot_load_arbiter_byte_assembler.sv
// Collects little-endian bytes into 32-bit words; done strobes with the 4th byte.
module byte_assembler
    import boot_load_arbiter_pkg::*;
(
    input  logic        clk,
    input  logic        rstn,
    input  logic        byte_vld_i,
    input  logic [7:0]  byte_i,
    output logic [1:0]  idx_o,
    output logic [31:0] word_o,
    output logic        done_o
);

    localparam logic [1:0] LAST_IDX = 2'(WORD_BYTES - 1);

    logic [1:0]  idx_q;
    logic [23:0] shift_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            idx_q   <= 2'd0;
            shift_q <= 24'd0;
        end else if (byte_vld_i) begin
            idx_q   <= idx_q + 2'd1;
            shift_q <= {byte_i, shift_q[23:8]};
        end
    end

    // The completed word is presented in the same cycle as its final byte.
    assign idx_o  = idx_q;
    assign word_o = {byte_i, shift_q};
    assign done_o = byte_vld_i && (idx_q == LAST_IDX);

endmodule

// File: rtl/boot_load_arbiter.sv
// Boot loader: receives a UART program image into RAM, then hands RAM and RX to the CPU.
module boot_load_arbiter
    import boot_load_arbiter_pkg::*;
#(
    parameter int ADDR_W    = 15,
    parameter int BASE_ADDR = 0,
    parameter int TIMEOUT   = 1_000_000
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [7:0]        rx_data,
    input  logic              rx_ready,
    input  logic              rx_ferr,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [31:0]       cpu_wdata,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_rx_ready,
    output logic              cpu_run,
    output logic              load_err,
    output logic [ADDR_W:0]   words_loaded,
    output load_state_e       state_dbg
);

    localparam logic [32:0]     CAPACITY = 33'd1 << ADDR_W;
    localparam logic [ADDR_W:0] ONE      = {{ADDR_W{1'b0}}, 1'b1};

    load_state_e       state_q;
    logic [ADDR_W:0]   n_q;
    logic [ADDR_W:0]   words_q;
    logic [31:0]       wdata_q;
    logic              we_q;
    logic [31:0]       tmo_q;
    logic              run_q;
    logic              err_q;

    logic              loading;
    logic              byte_vld;
    logic [1:0]        asm_idx;
    logic [31:0]       asm_word;
    logic              asm_done;
    logic [32:0]       hdr_end;
    logic [ADDR_W:0]   words_inc;
    logic              armed;
    logic              tmo_hit;
    logic              ferr_hit;

    assign loading   = (state_q == ST_HDR) || (state_q == ST_DATA);
    assign byte_vld  = loading && rx_ready && !rx_ferr;
    assign ferr_hit  = loading && rx_ready && rx_ferr;
    assign hdr_end   = {1'b0, asm_word} + 33'(BASE_ADDR);
    assign words_inc = words_q + ONE;

    // Idle in HDR between images is legal; only a partially received image can stall out.
    assign armed   = (state_q == ST_DATA) || ((state_q == ST_HDR) && (asm_idx != 2'd0));
    assign tmo_hit = (TIMEOUT != 0) && armed && !rx_ready && (tmo_q == 32'(TIMEOUT - 1));

    byte_assembler u_asm (
        .clk        (clk),
        .rstn       (rstn),
        .byte_vld_i (byte_vld),
        .byte_i     (rx_data),
        .idx_o      (asm_idx),
        .word_o     (asm_word),
        .done_o     (asm_done)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_HDR;
            n_q     <= '0;
            words_q <= '0;
            wdata_q <= 32'd0;
            we_q    <= 1'b0;
            tmo_q   <= 32'd0;
            run_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            we_q <= 1'b0;
            if (rx_ready || !armed) tmo_q <= 32'd0;
            else                    tmo_q <= tmo_q + 32'd1;

            case (state_q)
                ST_HDR: begin
                    if (ferr_hit || tmo_hit) begin
                        state_q <= ST_ERR;
                        err_q   <= 1'b1;
                    end else if (asm_done) begin
                        if (asm_word == 32'd0) begin
                            state_q <= ST_RUN;
                            run_q   <= 1'b1;
                        end else if (hdr_end > CAPACITY) begin
                            state_q <= ST_ERR;
                            err_q   <= 1'b1;
                        end else begin
                            n_q     <= asm_word[ADDR_W:0];
                            state_q <= ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    // The write pulse and byte collection overlap, so both are handled each cycle.
                    if (we_q) begin
                        words_q <= words_inc;
                        if (words_inc == n_q) begin
                            state_q <= ST_RUN;
                            run_q   <= 1'b1;
                        end
                    end
                    if (ferr_hit || tmo_hit) begin
                        state_q <= ST_ERR;
                        err_q   <= 1'b1;
                        run_q   <= 1'b0;
                    end else if (asm_done) begin
                        wdata_q <= asm_word;
                        we_q    <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        mem_we       = we_q;
        mem_addr     = ADDR_W'(BASE_ADDR) + words_q[ADDR_W-1:0];
        mem_wdata    = wdata_q;
        cpu_rx_ready = 1'b0;
        if (state_q == ST_RUN) begin
            mem_we       = cpu_we;
            mem_addr     = cpu_addr;
            mem_wdata    = cpu_wdata;
            cpu_rx_ready = rx_ready;
        end
    end

    assign cpu_run      = run_q;
    assign load_err     = err_q;
    assign words_loaded = words_q;
    assign state_dbg    = state_q;

endmodule

// File: tb/tb_boot_load_arbiter.sv
// Scoreboard bench for boot_load_arbiter: expected RAM writes and CPU RX strobes are queued, a monitor pops them.
module tb_boot_load_arbiter;
    import boot_load_arbiter_pkg::*;

    localparam int ADDR_W    = 4;
    localparam int BASE_ADDR = 0;
    localparam int TIMEOUT   = 100;

    logic              clk = 1'b0;
    logic              rstn = 1'b0;
    logic [7:0]        rx_data = 8'd0;
    logic              rx_ready = 1'b0;
    logic              rx_ferr = 1'b0;
    logic              cpu_we = 1'b0;
    logic [ADDR_W-1:0] cpu_addr = '0;
    logic [31:0]       cpu_wdata = 32'd0;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              cpu_rx_ready;
    logic              cpu_run;
    logic              load_err;
    logic [ADDR_W:0]   words_loaded;
    load_state_e       state_dbg;

    logic [ADDR_W+31:0] exp_q[$];
    logic [7:0]         exp_rx_q[$];
    logic [ADDR_W+31:0] mon_w;
    logic [7:0]         mon_b;
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    boot_load_arbiter #(
        .ADDR_W    (ADDR_W),
        .BASE_ADDR (BASE_ADDR),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk          (clk),
        .rstn         (rstn),
        .rx_data      (rx_data),
        .rx_ready     (rx_ready),
        .rx_ferr      (rx_ferr),
        .cpu_we       (cpu_we),
        .cpu_addr     (cpu_addr),
        .cpu_wdata    (cpu_wdata),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .cpu_rx_ready (cpu_rx_ready),
        .cpu_run      (cpu_run),
        .load_err     (load_err),
        .words_loaded (words_loaded),
        .state_dbg    (state_dbg)
    );

    // Monitor: every RAM write and CPU RX strobe must match the head of its queue.
    always @(negedge clk) begin
        if (mem_we) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_write: got addr=%h data=%h, expected no write", mem_addr, mem_wdata);
            end else begin
                mon_w = exp_q.pop_front();
                if ({mem_addr, mem_wdata} !== mon_w) begin
                    failures++;
                    $display("FAIL mem_write: got addr=%h data=%h, expected addr=%h data=%h",
                             mem_addr, mem_wdata, mon_w[ADDR_W+31:32], mon_w[31:0]);
                end
            end
        end
        if (cpu_rx_ready) begin
            checks++;
            if (exp_rx_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_cpu_rx: got byte=%h, expected no strobe", rx_data);
            end else begin
                mon_b = exp_rx_q.pop_front();
                if (rx_data !== mon_b) begin
                    failures++;
                    $display("FAIL cpu_rx: got byte=%h, expected %h", rx_data, mon_b);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic ferr);
        rx_data  = b;
        rx_ready = 1'b1;
        rx_ferr  = ferr;
        @(posedge clk);
        #1;
        rx_ready = 1'b0;
        rx_ferr  = 1'b0;
    endtask

    task automatic send_word32(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], 1'b0);
    endtask

    task automatic send_data_word(input logic [ADDR_W-1:0] addr, input logic [31:0] w);
        exp_q.push_back({addr, w});
        send_word32(w);
    endtask

    task automatic do_reset();
        rstn   = 1'b0;
        cpu_we = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
    endtask

    initial begin
        logic [31:0] w;

        // Reset state
        do_reset();
        @(negedge clk);
        check("rst_cpu_run", 32'(cpu_run), 32'd0);
        check("rst_load_err", 32'(load_err), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_words", 32'(words_loaded), 32'd0);
        check("rst_cpu_rx_ready", 32'(cpu_rx_ready), 32'd0);
        check("rst_state", 32'(state_dbg), 32'(ST_HDR));

        // Two-word image, bytes back to back (a byte lands while mem_we is high)
        send_word32(32'd2);
        send_data_word(4'd0, 32'h1122_3344);
        send_data_word(4'd1, 32'hDEAD_BEEF);
        @(negedge clk);
        check("t1_run_during_write", 32'(cpu_run), 32'd0);
        check("t1_words_during_write", 32'(words_loaded), 32'd1);
        @(negedge clk);
        check("t1_run_after_write", 32'(cpu_run), 32'd1);
        check("t1_words_final", 32'(words_loaded), 32'd2);
        check("t1_state", 32'(state_dbg), 32'(ST_RUN));

        // Empty image goes straight to RUN
        do_reset();
        send_word32(32'd0);
        @(negedge clk);
        check("t2_cpu_run", 32'(cpu_run), 32'd1);
        check("t2_words", 32'(words_loaded), 32'd0);
        check("t2_load_err", 32'(load_err), 32'd0);

        // Oversized header: 2**ADDR_W + 1 words; CPU writes and later bytes must not reach RAM
        do_reset();
        cpu_we    = 1'b1;
        cpu_addr  = 4'd3;
        cpu_wdata = 32'h5555_AAAA;
        send_word32(32'd17);
        for (int i = 0; i < 8; i++) send_byte(8'(i + 8'h30), 1'b0);
        @(negedge clk);
        check("t3_load_err", 32'(load_err), 32'd1);
        check("t3_cpu_run", 32'(cpu_run), 32'd0);
        check("t3_state", 32'(state_dbg), 32'(ST_ERR));
        cpu_we = 1'b0;

        // Long idle before a header never times out; a stall inside an image does
        do_reset();
        repeat (1000) @(negedge clk);
        check("t5_idle_no_err", 32'(load_err), 32'd0);
        check("t5_idle_state", 32'(state_dbg), 32'(ST_HDR));
        send_word32(32'd1);
        send_byte(8'h01, 1'b0);
        send_byte(8'h02, 1'b0);
        repeat (100) @(negedge clk);
        check("t5_stall_99_no_err", 32'(load_err), 32'd0);
        @(negedge clk);
        check("t5_stall_100_err", 32'(load_err), 32'd1);
        check("t5_state", 32'(state_dbg), 32'(ST_ERR));

        // Framing error on 3rd byte of word 0
        do_reset();
        send_word32(32'd2);
        send_byte(8'hAA, 1'b0);
        send_byte(8'hBB, 1'b0);
        send_byte(8'hCC, 1'b1);
        send_byte(8'hDD, 1'b0);
        send_byte(8'hEE, 1'b0);
        @(negedge clk);
        check("t4_ferr_err", 32'(load_err), 32'd1);
        check("t4_ferr_words", 32'(words_loaded), 32'd0);

        // Asynchronous reset clears the error; then a full-capacity image with uneven spacing
        rstn = 1'b0;
        #1;
        check("t4_async_err_clear", 32'(load_err), 32'd0);
        check("t4_async_state", 32'(state_dbg), 32'(ST_HDR));
        @(posedge clk);
        #1;
        rstn = 1'b1;
        send_word32(32'd16);
        for (int k = 0; k < 16; k++) begin
            w = {4{8'(k)}} ^ 32'h0F1E_2D3C;
            send_data_word(4'(k), w);
            repeat (k % 3) @(posedge clk);
            #1;
        end
        repeat (2) @(negedge clk);
        check("t4_full_words", 32'(words_loaded), 32'd16);
        check("t4_full_run", 32'(cpu_run), 32'd1);
        check("t4_full_err", 32'(load_err), 32'd0);

        // RUN: CPU port passes straight through, RX forwarded, framing errors ignored
        @(posedge clk);
        #1;
        exp_q.push_back({4'd5, 32'hCAFE_F00D});
        cpu_we    = 1'b1;
        cpu_addr  = 4'd5;
        cpu_wdata = 32'hCAFE_F00D;
        @(posedge clk);
        #1;
        cpu_we   = 1'b0;
        cpu_addr = 4'd7;
        @(negedge clk);
        check("t6_addr_passthru", 32'(mem_addr), 32'd7);
        exp_rx_q.push_back(8'h41);
        send_byte(8'h41, 1'b0);
        exp_rx_q.push_back(8'h42);
        send_byte(8'h42, 1'b1);
        @(negedge clk);
        check("t6_run_err", 32'(load_err), 32'd0);
        check("t6_run_held", 32'(cpu_run), 32'd1);

        repeat (3) @(negedge clk);
        check("pending_writes", 32'(exp_q.size()), 32'd0);
        check("pending_rx", 32'(exp_rx_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
